mar_reader: RTL and testbench

Read-side counterpart to the memory address register: a small register bank that the MAR write path loads word-by-word, plus a burst-read sequencer that streams a run of stored words out over a valid/ready handshake. It sits between the MAR load logic (write port) and any downstream consumer (read port) inside the tile top level. Each burst walks consecutive addresses with wrap-around and reports completion with a one-cycle pulse.

---
 rtl/mar_pkg.sv | 18 +
 rtl/mar_regfile.sv | 38 +++
 rtl/mar_reader.sv | 101 ++++++++++
 tb/tb_mar_reader.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mar_pkg.sv
// Shared parameters, address-width helper and FSM state encoding for the MAR read path.
package mar_pkg;

    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned DEPTH_DEF  = 4;

    // Address width for a bank of the given depth (at least one bit)
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/mar_regfile.sv
// DEPTH x DATA_W register bank: one write port, one combinational read port.
// The read port bypasses a same-cycle write to the same address (write-first).
module mar_regfile
    import mar_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_sel,
    output logic [DATA_W-1:0] rd_word_c
);

    logic [DATA_W-1:0] bank [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else if (wr_en) begin
            bank[wr_sel] <= wr_data;
        end
    end

    always_comb begin
        rd_word_c = bank[rd_sel];
        if (wr_en && (wr_sel == rd_sel)) begin
            rd_word_c = wr_data;
        end
    end

endmodule

// File: rtl/mar_reader.sv
// Burst-read sequencer over the MAR register bank: streams consecutive words
// (wrapping at DEPTH) over valid/ready and pulses done after the last accept.
module mar_reader
    import mar_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_sel,
    input  logic [ADDR_W:0]   burst_len,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_sel,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W + 1)'(1);

    state_e              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W:0]     remaining;
    logic [ADDR_W:0]     len_clamped_c;
    logic [ADDR_W-1:0]   ld_sel_c;
    logic [DATA_W-1:0]   ld_word_c;

    // Address of the word loaded at this edge: burst start in IDLE, next word otherwise
    always_comb begin
        ld_sel_c      = (state == IDLE) ? start_sel : ptr + ADDR_W'(1);
        len_clamped_c = (burst_len > DEPTH_L) ? DEPTH_L : burst_len;
    end

    mar_regfile #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .rd_sel    (ld_sel_c),
        .rd_word_c (ld_word_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            rd_data   <= '0;
            rd_sel    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (burst_len != '0)) begin
                        ptr       <= start_sel;
                        remaining <= len_clamped_c;
                        rd_data   <= ld_word_c;
                        rd_sel    <= start_sel;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    // Without a handshake the presented word is a frozen snapshot
                    if (rd_ready) begin
                        if (remaining == ONE_L) begin
                            state <= DONE;
                        end else begin
                            ptr       <= ld_sel_c;
                            remaining <= remaining - ONE_L;
                            rd_data   <= ld_word_c;
                            rd_sel    <= ld_sel_c;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags decode state only, so no input reaches them combinationally
    assign rd_valid = (state == PRESENT);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_mar_reader.sv
// Scoreboard bench for mar_reader: stimulus pushes hand-computed words,
// a negedge monitor pops and compares on every handshake and checks done timing.
module tb_mar_reader;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 2;

    typedef struct {
        logic [ADDR_W-1:0] sel;
        logic [DATA_W-1:0] data;
        bit                last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [ADDR_W-1:0] start_sel;
    logic [ADDR_W:0]   burst_len;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_sel;
    logic              rd_valid;
    logic              rd_ready;
    logic              busy;
    logic              done;

    exp_t sb_q[$];
    bit   done_exp;
    int   n_checks;
    int   n_pass;

    mar_reader #(.DATA_W(DATA_W), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .start     (start),
        .start_sel (start_sel),
        .burst_len (burst_len),
        .rd_data   (rd_data),
        .rd_sel    (rd_sel),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic push(input logic [ADDR_W-1:0] s, input logic [DATA_W-1:0] d, input bit l);
        exp_t e;
        e.sel = s; e.data = d; e.last = l;
        sb_q.push_back(e);
    endtask

    task automatic write(input logic [ADDR_W-1:0] s, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_sel = s; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic burst(input logic [ADDR_W-1:0] s, input logic [ADDR_W:0] len);
        start = 1'b1; start_sel = s; burst_len = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Monitor: compares presented/accepted words and the done pulse every cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("done", 32'(done), 32'(done_exp));
            done_exp = 1'b0;
            if (rd_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_word", 32'(rd_valid), 32'd0);
                end else begin
                    chk("rd_sel", 32'(rd_sel), 32'(sb_q[0].sel));
                    chk("rd_data", 32'(rd_data), 32'(sb_q[0].data));
                    if (rd_ready) begin
                        done_exp = sb_q[0].last;
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        n_checks = 0; n_pass = 0; done_exp = 1'b0;
        rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
        start = 1'b0; start_sel = '0; burst_len = '0; rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_rd_sel", 32'(rd_sel), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Load bank = {A, 5, F, 3}
        write(2'd0, 4'hA); write(2'd1, 4'h5); write(2'd2, 4'hF); write(2'd3, 4'h3);

        // Basic 3-word burst from address 1
        push(2'd1, 4'h5, 0); push(2'd2, 4'hF, 0); push(2'd3, 4'h3, 1);
        burst(2'd1, 3'd3);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_idle("b1");

        // Wrap-around full burst from address 3
        push(2'd3, 4'h3, 0); push(2'd0, 4'hA, 0); push(2'd1, 4'h5, 0); push(2'd2, 4'hF, 1);
        burst(2'd3, 3'd4);
        wait_idle("b2");

        // Backpressure on word 2 while that address is overwritten with 0
        push(2'd1, 4'h5, 0); push(2'd2, 4'hF, 0); push(2'd3, 4'h3, 1);
        burst(2'd1, 3'd3);
        @(posedge clk); #1;
        rd_ready = 1'b0; wr_en = 1'b1; wr_sel = 2'd2; wr_data = 4'h0;
        repeat (3) begin @(posedge clk); #1; end
        wr_en = 1'b0; rd_ready = 1'b1;
        wait_idle("b3");

        // Forwarding: write addr 1 = 9 in the start cycle
        push(2'd1, 4'h9, 1);
        wr_en = 1'b1; wr_sel = 2'd1; wr_data = 4'h9;
        burst(2'd1, 3'd1);
        wr_en = 1'b0;
        wait_idle("b4");

        // burst_len = 0 is ignored
        burst(2'd2, 3'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("len0_valid", 32'(rd_valid), 32'd0);
        chk("len0_busy", 32'(busy), 32'd0);

        // start while busy is ignored (bank is now {A, 9, 0, 3})
        push(2'd0, 4'hA, 0); push(2'd1, 4'h9, 1);
        rd_ready = 1'b0;
        burst(2'd0, 3'd2);
        start = 1'b1; start_sel = 2'd2; burst_len = 3'd1;
        @(posedge clk); #1;
        start = 1'b0; rd_ready = 1'b1;
        wait_idle("b5");
        repeat (3) begin @(posedge clk); #1; end
        chk("busy_start_ignored", 32'(rd_valid), 32'd0);

        // Oversized length clamps to DEPTH
        push(2'd2, 4'h0, 0); push(2'd3, 4'h3, 0); push(2'd0, 4'hA, 0); push(2'd1, 4'h9, 1);
        burst(2'd2, 3'd7);
        wait_idle("b6");

        // Reset during the second word of a 4-word burst
        push(2'd0, 4'hA, 0); push(2'd1, 4'h9, 0); push(2'd2, 4'h0, 0); push(2'd3, 4'h3, 1);
        burst(2'd0, 3'd4);
        @(posedge clk); #1;
        rst = 1'b1;
        sb_q.delete();
        done_exp = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rd_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push(2'd0, 4'h0, 1);
        burst(2'd0, 3'd1);
        wait_idle("b7");

        repeat (2) begin @(posedge clk); #1; end
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
